// File: rtl/mips_bus_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mips_bus_mem_bridge
// Purpose : Avalon-MM CPU port to single-port word RAM bridge with range
//           checking and wait-state insertion. Optional random extra waits
//           when BUS_RANDOM_WAIT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module mips_bus_mem_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'hBFC00000,
  parameter int          RAM_ADDR_WIDTH = 14,
  parameter int          WAIT_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               address,
  input  logic                      read,
  input  logic                      write,
  input  logic [3:0]                byteenable,
  input  logic [31:0]               writedata,
  output logic                      waitrequest,
  output logic [31:0]               readdata,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_we,
  output logic [3:0]                ram_be,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata,
  output logic                      err_range,
  output logic [31:0]               err_addr
);

`ifdef BUS_RANDOM_WAIT_EN
  localparam int CNT_MAX = WAIT_CYCLES + 3;
`else
  localparam int CNT_MAX = WAIT_CYCLES;
`endif
  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_wait   = CNT_W'(WAIT_CYCLES);
  localparam logic [32:0]      c_window = 33'(64'd4 << RAM_ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t              r_state;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic                r_write;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_readdata;

  logic                w_req;
  logic [31:0]         w_in_off;
  logic                w_in_err;
  logic [31:0]         w_sel_addr;
  logic [31:0]         w_sel_off;
  logic [31:0]         w_sel_wdata;
  logic [3:0]          w_sel_be;
  logic                w_sel_write;
  logic                w_sel_err;
  logic [RAM_ADDR_WIDTH-1:0] w_sel_word;
  logic [CNT_W-1:0]    w_total;
  logic                w_to_access;
  logic                w_complete;
  logic [31:0]         w_resp_data;
  logic                w_wait;

  assign w_req    = read | write;
  assign w_in_off = address - BASE_ADDR;
  // 33-bit compare so a window covering the full 4 GB cannot wrap
  assign w_in_err = (address < BASE_ADDR) | ({1'b0, w_in_off} >= c_window) |
                    (address[1:0] != 2'b00) | (read & write);

  // In IDLE the RAM side is loaded straight from the bus (zero-wait path)
  assign w_sel_addr  = (r_state == IDLE) ? address    : r_addr;
  assign w_sel_wdata = (r_state == IDLE) ? writedata  : r_wdata;
  assign w_sel_be    = (r_state == IDLE) ? byteenable : r_be;
  assign w_sel_write = (r_state == IDLE) ? write      : r_write;
  assign w_sel_err   = (r_state == IDLE) ? w_in_err   : r_err;
  assign w_sel_off   = w_sel_addr - BASE_ADDR;
  assign w_sel_word  = RAM_ADDR_WIDTH'(w_sel_off >> 2);

`ifdef BUS_RANDOM_WAIT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lfsr <= 8'hA5;
    else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_total = c_wait + CNT_W'(r_lfsr[1:0]);
`else
  assign w_total = c_wait;
`endif

  assign w_to_access = ((r_state == IDLE) && w_req && (w_total == '0)) ||
                       ((r_state == WAIT) && (r_cnt == '0));
  assign w_complete  = ((r_state == ACCESS) && r_write) || (r_state == RESP);
  assign w_resp_data = r_err ? 32'h0000_0000 : ram_rdata;
  assign readdata    = (r_state == RESP) ? w_resp_data : r_readdata;

  always_comb begin
    w_wait = 1'b1;
    case (r_state)
      IDLE:    w_wait = w_req;
      WAIT:    w_wait = 1'b1;
      ACCESS:  w_wait = ~r_write;
      RESP:    w_wait = 1'b0;
      default: w_wait = 1'b1;
    endcase
  end

  assign waitrequest = ~reset_n | w_wait;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_readdata <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_be     <= '0;
      ram_wdata  <= '0;
      err_range  <= 1'b0;
      err_addr   <= '0;
    end else begin
      ram_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= address;
            r_wdata <= writedata;
            r_be    <= byteenable;
            r_write <= write;
            r_err   <= w_in_err;
            r_cnt   <= w_total - CNT_W'(1);
            r_state <= (w_total == '0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= ACCESS;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        ACCESS: r_state <= r_write ? IDLE : RESP;
        RESP: begin
          r_readdata <= w_resp_data;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_to_access) begin
        ram_addr  <= w_sel_word;
        ram_be    <= w_sel_be;
        ram_wdata <= w_sel_wdata;
        ram_we    <= w_sel_write & ~w_sel_err;
      end

      if (w_complete && r_err) begin
        err_range <= 1'b1;
        if (!err_range) err_addr <= r_addr;
      end
    end
  end

endmodule
`default_nettype wire
